muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit, directly downstream of the register file.
- Consumes the two read operands (rdat1/rdat2) plus decoded funct3/rd.
- Produces one write-back beat (wb_we/wb_waddr/wb_wdat) that drives the register file write port.
- The core stalls on busy while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 19 +
 rtl/muldiv_iter_dp.sv | 48 ++++
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] INT_MIN   = {1'b1, {(XLEN_DEF-1){1'b0}}};
endpackage

// File: rtl/muldiv_if.sv
// Request / write-back bundle between the issue stage and the mul/div unit.
interface muldiv_if #(parameter int XLEN = muldiv_pkg::XLEN_DEF);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            wb_we;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdat;

  modport master (output start, funct3, op_a, op_b, rd,
                  input  busy, done, result, wb_we, wb_waddr, wb_wdat);
  modport slave  (input  start, funct3, op_a, op_b, rd,
                  output busy, done, result, wb_we, wb_waddr, wb_wdat);
endinterface

// File: rtl/muldiv_iter_dp.sv
// Radix-2 datapath: shift-add multiply or restoring divide on magnitudes.
// {hi,lo} holds the product, or remainder/quotient, after XLEN steps.
module muldiv_iter_dp #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  logic [XLEN-1:0] b_q;
  logic [XLEN:0]   add_sum, rem_sh, rem_sub;

  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    rem_sh  = {hi, lo[XLEN-1]};
    rem_sub = rem_sh - {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a_in;
      b_q <= b_in;
    end else if (step) begin
      if (is_div) begin
        // MSB of the trial difference is set exactly when the divisor does not fit
        if (!rem_sub[XLEN]) begin
          hi <= rem_sub[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= rem_sh[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= add_sum[XLEN:1];
        lo <= {add_sum[0], lo[XLEN-1:1]};
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back beat.
// Build option: MULDIV_FAST_MUL_EN gives the four MUL ops a one-cycle multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

  state_t            state, nstate;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_q, spec_q;
  logic [XLEN-1:0]   spec_val_q, result_q, dp_hi, dp_lo, fin;
  logic              sa, sb, a_neg, b_neg, neg_in, is_div_in, spec_hit;
  logic [XLEN-1:0]   a_mag, b_mag, spec_val;
  logic [2*XLEN-1:0] prod, prod_f;
  logic              accept, step;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
`endif

  assign accept = (state == S_IDLE) && bus.start;
  assign step   = (state == S_CALC) && (cnt != LAST);

  // Operand signs and magnitudes; MUL is treated as unsigned since its low word is sign-agnostic
  always_comb begin
    is_div_in = bus.funct3[2];
    sa        = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
                (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
    sb        = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    a_neg     = sa && bus.op_a[XLEN-1];
    b_neg     = sb && bus.op_b[XLEN-1];
    a_mag     = a_neg ? -bus.op_a : bus.op_a;
    b_mag     = b_neg ? -bus.op_b : bus.op_b;
    neg_in    = (is_div_in && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
`ifdef MULDIV_FAST_MUL_EN
    fprod    = '0;
`endif
    if (is_div_in && bus.op_b == '0) begin
      spec_hit = 1'b1;
      spec_val = bus.funct3[1] ? bus.op_a : DIV0_QUOT;
    end else if (is_div_in && !bus.funct3[0] && bus.op_a == INT_MIN && bus.op_b == '1) begin
      spec_hit = 1'b1;
      spec_val = bus.funct3[1] ? '0 : INT_MIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div_in) begin
      spec_hit = 1'b1;
      fprod    = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
      if (neg_in) fprod = -fprod;
      spec_val = (bus.funct3 == F3_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk(clk), .rst(rst), .load(accept), .step(step), .is_div(f3_q[2]),
    .a_in(a_mag), .b_in(b_mag), .hi(dp_hi), .lo(dp_lo)
  );

  always_comb begin
    prod   = {dp_hi, dp_lo};
    prod_f = neg_q ? -prod : prod;
    if (spec_q)          fin = spec_val_q;
    else if (!f3_q[2])   fin = (f3_q == F3_MUL) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    else if (!f3_q[1])   fin = neg_q ? -dp_lo : dp_lo;
    else                 fin = neg_q ? -dp_hi : dp_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (bus.start) nstate = S_CALC;
      S_CALC:  if (cnt == LAST) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.done     = (state == S_DONE);
    bus.result   = result_q;
    bus.wb_wdat  = result_q;
    bus.wb_waddr = rd_q;
    bus.wb_we    = (state == S_DONE) && (rd_q != 5'd0);
  end

  // Special/fast results take one fixup-only CALC cycle (counter preset to LAST)
  // so the result register has a single load point.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else if (accept) begin
      cnt        <= spec_hit ? LAST : '0;
      f3_q       <= bus.funct3;
      rd_q       <= bus.rd;
      neg_q      <= neg_in;
      spec_q     <= spec_hit;
      spec_val_q <= spec_val;
    end else if (state == S_CALC) begin
      if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt      <= '0;
        result_q <= fin;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops vs. an arithmetic model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic [31:0] last_res;

  muldiv_if #(.XLEN(32)) bus();
  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    longint unsigned pu, u1, u2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    u1 = {32'h0, a};
    u2 = {32'h0, b};
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin pu = u1 * u2; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 2;
    if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 2;
`endif
    return 34;
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit poke);
    logic [31:0] exp;
    int lat, elat;
    bit seen, busy_ok;
    exp  = ref_model(f3, a, b);
    elat = exp_latency(f3, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd = r;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom; bus.funct3 = 3'($urandom); bus.rd = 5'($urandom);
    lat = 1; seen = 0; busy_ok = 1;
    while (!seen && lat < 100) begin
      if (!bus.busy) busy_ok = 0;
      if (bus.done) seen = 1;
      else begin
        if (poke && lat == 5) bus.start = 1'b1;
        if (poke && lat == 8) bus.start = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    check("latency", 64'(lat), 64'(elat));
    check("busy_through_op", 64'(busy_ok), 64'd1);
    check("result", 64'(bus.result), 64'(exp));
    check("wb_wdat", 64'(bus.wb_wdat), 64'(exp));
    check("wb_waddr", 64'(bus.wb_waddr), 64'(r));
    check("wb_we", 64'(bus.wb_we), 64'(r != 0));
    last_res = bus.result;
    @(negedge clk);
    check("done_one_cycle", 64'({bus.done, bus.busy}), 64'd0);
    check("result_held", 64'(bus.result), 64'(exp));
  endtask

  initial begin
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.op_a = '0; bus.op_b = '0; bus.rd = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_wb_we", 64'(bus.wb_we), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_wb_waddr", 64'(bus.wb_waddr), 64'd0);
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'd6, 5'd5, 0);                    check("tp_mul", 64'(last_res), 64'd42);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);    check("tp_mulh", 64'(last_res), 64'h0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);    check("tp_mulhu", 64'(last_res), 64'hFFFF_FFFE);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);    check("tp_mulhsu", 64'(last_res), 64'hFFFF_FFFF);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);            check("tp_div", 64'(last_res), 64'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);            check("tp_rem", 64'(last_res), 64'hFFFF_FFFF);
    run_op(3'b101, 32'd100, 32'd7, 5'd6, 0);                  check("tp_divu", 64'(last_res), 64'd14);
    run_op(3'b111, 32'd100, 32'd7, 5'd6, 0);                  check("tp_remu", 64'(last_res), 64'd2);
    run_op(3'b101, 32'h1234, 32'd0, 5'd7, 0);                 check("tp_div0", 64'(last_res), 64'hFFFF_FFFF);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);    check("tp_rem_ovf", 64'(last_res), 64'd0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);    check("tp_div_ovf", 64'(last_res), 64'h8000_0000);
    run_op(3'b000, 32'd11, 32'd13, 5'd0, 0);                  check("tp_rd0", 64'(last_res), 64'd143);
    run_op(3'b000, 32'd1000, 32'd1000, 5'd9, 1);              check("tp_poke", 64'(last_res), 64'd1000000);

    // Abort mid-operation with reset, then a fresh op must complete normally
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.rd = 5'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    rst = 1'b0;
    run_op(3'b000, 32'd3, 32'd3, 5'd11, 0);                   check("tp_after_abort", 64'(last_res), 64'd9);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'($urandom_range(1, 9)) | (b & 32'h8000_0000);
        default: ;
      endcase
      run_op(f3, a, b, 5'($urandom), i[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
